// File: rtl/eh2_pkg.sv
// Shared types for the EH2 execution-unit divider.
package eh2_pkg;

    // Widest thread id the divider packet can carry; the divider zero-extends
    // its own thread id into this field.
    localparam int EH2_DIV_TIDW = 4;

    typedef enum logic [2:0] {
        DIV_IDLE,
        DIV_SKIP,
        DIV_ITER,
        DIV_FIX,
        DIV_DONE
    } eh2_div_gen_state_t;

    typedef struct packed {
        logic                    valid;
        logic                    unsign;
        logic                    rem;
        logic [EH2_DIV_TIDW-1:0] tid;
    } eh2_div_gen_pkt_t;

    // Width of the iteration counter: must hold WIDTH/BPC itself.
    function automatic int eh2_div_cntw(input int w, input int bpc);
        return $clog2(w / bpc) + 1;
    endfunction

endpackage

// File: rtl/eh2_div_lzc.sv
// Leading-zero counter; an all-zero input reports WIDTH.
module eh2_div_lzc #(
    parameter  int WIDTH = 32,
    localparam int CW    = $clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0] i_data,
    output logic [CW-1:0]    o_lz
);

    // Scan upward so the most significant set bit wins.
    always_comb begin
        o_lz = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (i_data[i]) o_lz = CW'(WIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/eh2_exu_div_gen.sv
// Iterative restoring divider: BPC quotient bits per cycle, leading-zero
// early-out, fixed-latency RISC-V special cases, per-thread cancel.
module eh2_exu_div_gen
    import eh2_pkg::*;
#(
    parameter  int WIDTH       = 32,
    parameter  int BPC         = 1,
    parameter  int NUM_THREADS = 2,
    localparam int TIDW        = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [TIDW-1:0]  in_tid,
    input  logic             in_unsign,
    input  logic             in_rem,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             cancel,
    input  logic [TIDW-1:0]  cancel_tid,
    output logic             busy,
    output logic             out_valid,
    output logic [TIDW-1:0]  out_tid,
    output logic [WIDTH-1:0] out
);

    localparam int LZW  = $clog2(WIDTH) + 1;
    localparam int CNTW = eh2_div_cntw(WIDTH, BPC);
    localparam int BSH  = $clog2(BPC);

    eh2_div_gen_state_t r_state, w_state_nxt;
    eh2_div_gen_pkt_t   r_pkt;
    logic               r_neg_a, r_neg_b;
    logic [WIDTH-1:0]   r_a;      // |A|, shifted out MSB-first during ITER
    logic [WIDTH-1:0]   r_b;      // |B|
    logic [WIDTH-1:0]   r_rmd;    // partial remainder
    logic [WIDTH-1:0]   r_q;      // quotient shift register
    logic [CNTW-1:0]    r_cnt;
    logic [WIDTH-1:0]   r_out;
    logic [TIDW-1:0]    r_out_tid;

    logic               w_acc, w_kill;
    logic               w_div0, w_ovf, w_special;
    logic [LZW-1:0]     w_lz, w_skip, w_nbits;
    logic [CNTW-1:0]    w_n;
    logic [WIDTH-1:0]   w_min, w_sa, w_spec_res, w_fix_res;
    logic [WIDTH-1:0]   w_in_abs_a, w_in_abs_b;

    // ---------------------------------------------------------------
    // Handshake and cancel qualification
    // ---------------------------------------------------------------
    assign in_ready  = ~rst & ((r_state == DIV_IDLE) | (r_state == DIV_DONE));
    // A request flushed in the same cycle it is offered is never taken.
    assign w_acc     = in_valid & in_ready & ~(cancel & (cancel_tid == in_tid));
    assign w_kill    = cancel & (r_pkt.tid == EH2_DIV_TIDW'(cancel_tid));
    assign busy      = (r_state != DIV_IDLE);
    assign out_valid = (r_state == DIV_DONE) & r_pkt.valid & ~w_kill;
    assign out       = r_out;
    assign out_tid   = r_out_tid;

    assign w_in_abs_a = (~in_unsign & dividend[WIDTH-1]) ? -dividend : dividend;
    assign w_in_abs_b = (~in_unsign & divisor[WIDTH-1])  ? -divisor  : divisor;

    // ---------------------------------------------------------------
    // SKIP-cycle decode: special cases and leading-zero early-out
    // ---------------------------------------------------------------
    assign w_min     = {1'b1, {(WIDTH-1){1'b0}}};
    assign w_div0    = (r_b == '0);
    // Signed most-negative / -1: both magnitudes are exact (2^(W-1) and 1).
    assign w_ovf     = ~r_pkt.unsign & r_neg_a & r_neg_b & (r_a == w_min)
                     & (r_b == WIDTH'(1));
    assign w_special = w_div0 | w_ovf;
    // Original dividend rebuilt from magnitude and sign.
    assign w_sa      = r_neg_a ? -r_a : r_a;
    assign w_spec_res = w_div0 ? (r_pkt.rem ? w_sa : '1)
                               : (r_pkt.rem ? '0   : w_sa);

    eh2_div_lzc #(.WIDTH(WIDTH)) u_lzc (
        .i_data (r_a),
        .o_lz   (w_lz)
    );

    // Round the skip down to a whole number of iteration cycles.
    assign w_skip  = w_lz & ~LZW'(BPC - 1);
    assign w_nbits = LZW'(WIDTH) - w_skip;
    assign w_n     = CNTW'(w_nbits >> BSH);

    // ---------------------------------------------------------------
    // BPC cascaded restoring steps
    // ---------------------------------------------------------------
    logic [WIDTH-1:0] w_rmd [BPC+1];
    logic [WIDTH-1:0] w_ap  [BPC+1];
    logic [WIDTH-1:0] w_qp  [BPC+1];

    assign w_rmd[0] = r_rmd;
    assign w_ap[0]  = r_a;
    assign w_qp[0]  = r_q;

    for (genvar g = 0; g < BPC; g++) begin : g_step
        logic [WIDTH:0]   w_sh;
        logic [WIDTH-1:0] w_sub;
        logic             w_ge;
        assign w_sh  = {w_rmd[g], w_ap[g][WIDTH-1]};
        assign w_ge  = (w_sh >= {1'b0, r_b});
        // When w_ge the difference is below |B|, so it fits WIDTH bits.
        assign w_sub = w_sh[WIDTH-1:0] - r_b;
        assign w_rmd[g+1] = w_ge ? w_sub : w_sh[WIDTH-1:0];
        assign w_ap[g+1]  = {w_ap[g][WIDTH-2:0], 1'b0};
        assign w_qp[g+1]  = {w_qp[g][WIDTH-2:0], w_ge};
    end

    // Sign fix-up and result select.
    assign w_fix_res = r_pkt.rem
        ? ((~r_pkt.unsign & r_neg_a)             ? -r_rmd : r_rmd)
        : ((~r_pkt.unsign & (r_neg_a ^ r_neg_b)) ? -r_q   : r_q);

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= DIV_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state decode; a matching cancel collapses any live op to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            DIV_IDLE: if (w_acc) w_state_nxt = DIV_SKIP;
            DIV_SKIP: begin
                if (w_special)       w_state_nxt = DIV_DONE;
                else if (w_n == '0)  w_state_nxt = DIV_FIX;
                else                 w_state_nxt = DIV_ITER;
            end
            DIV_ITER: if (r_cnt == CNTW'(1)) w_state_nxt = DIV_FIX;
            DIV_FIX:  w_state_nxt = DIV_DONE;
            // The finished op is already retired (or suppressed); a new
            // request handshaken here must not be lost, so it still starts.
            DIV_DONE: w_state_nxt = w_acc ? DIV_SKIP : DIV_IDLE;
            default:  w_state_nxt = DIV_IDLE;
        endcase
        if (w_kill && (r_state == DIV_SKIP || r_state == DIV_ITER ||
                       r_state == DIV_FIX))
            w_state_nxt = DIV_IDLE;
    end

    // Datapath: operand capture, pre-shift, iteration and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pkt     <= '0;
            r_neg_a   <= 1'b0;
            r_neg_b   <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_rmd     <= '0;
            r_q       <= '0;
            r_cnt     <= '0;
            r_out     <= '0;
            r_out_tid <= '0;
        end else begin
            if (w_state_nxt == DIV_IDLE) r_pkt.valid <= 1'b0;
            case (r_state)
                DIV_SKIP: begin
                    r_a   <= r_a << w_skip;
                    r_rmd <= '0;
                    r_q   <= '0;
                    r_cnt <= w_n;
                    if (w_special && !w_kill) begin
                        r_out     <= w_spec_res;
                        r_out_tid <= r_pkt.tid[TIDW-1:0];
                    end
                end
                DIV_ITER: begin
                    r_rmd <= w_rmd[BPC];
                    r_a   <= w_ap[BPC];
                    r_q   <= w_qp[BPC];
                    r_cnt <= r_cnt - CNTW'(1);
                end
                DIV_FIX: begin
                    if (!w_kill) begin
                        r_out     <= w_fix_res;
                        r_out_tid <= r_pkt.tid[TIDW-1:0];
                    end
                end
                default: ;
            endcase
            if (w_acc) begin
                r_pkt.valid  <= 1'b1;
                r_pkt.unsign <= in_unsign;
                r_pkt.rem    <= in_rem;
                r_pkt.tid    <= EH2_DIV_TIDW'(in_tid);
                r_neg_a      <= ~in_unsign & dividend[WIDTH-1];
                r_neg_b      <= ~in_unsign & divisor[WIDTH-1];
                r_a          <= w_in_abs_a;
                r_b          <= w_in_abs_b;
            end
        end
    end

endmodule

// File: tb/tb_eh2_exu_div_gen.sv
// Bench: a 32-bit radix-2 and a 64-bit radix-16 divider, directed test-plan
// cases plus random operations checked against an arithmetic model.
module tb_eh2_exu_div_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;          // 0 = 32-bit instance, 1 = 64-bit
    logic        in_valid = 1'b0;
    logic [0:0]  in_tid = '0;
    logic        in_unsign = 1'b0;
    logic        in_rem = 1'b0;
    logic [63:0] dividend = '0;
    logic [63:0] divisor = '0;
    logic        cancel = 1'b0;
    logic [0:0]  cancel_tid = '0;

    logic        r0_ready, r0_busy, r0_valid;
    logic [0:0]  r0_tid;
    logic [31:0] r0_out;
    logic        r1_ready, r1_busy, r1_valid;
    logic [0:0]  r1_tid;
    logic [63:0] r1_out;

    logic        m_ready, m_busy, m_valid;
    logic [0:0]  m_tid;
    logic [63:0] m_out;

    int          ntot = 0;
    int          npass = 0;
    logic [63:0] prev [2];

    always #5 clk = ~clk;

    eh2_exu_div_gen #(.WIDTH(32), .BPC(1), .NUM_THREADS(2)) u_div32 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid & ~sel), .in_ready(r0_ready), .in_tid(in_tid),
        .in_unsign(in_unsign), .in_rem(in_rem),
        .dividend(dividend[31:0]), .divisor(divisor[31:0]),
        .cancel(cancel & ~sel), .cancel_tid(cancel_tid),
        .busy(r0_busy), .out_valid(r0_valid), .out_tid(r0_tid), .out(r0_out)
    );

    eh2_exu_div_gen #(.WIDTH(64), .BPC(4), .NUM_THREADS(2)) u_div64 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid & sel), .in_ready(r1_ready), .in_tid(in_tid),
        .in_unsign(in_unsign), .in_rem(in_rem),
        .dividend(dividend), .divisor(divisor),
        .cancel(cancel & sel), .cancel_tid(cancel_tid),
        .busy(r1_busy), .out_valid(r1_valid), .out_tid(r1_tid), .out(r1_out)
    );

    assign m_ready = sel ? r1_ready : r0_ready;
    assign m_busy  = sel ? r1_busy  : r0_busy;
    assign m_valid = sel ? r1_valid : r0_valid;
    assign m_tid   = sel ? r1_tid   : r0_tid;
    assign m_out   = sel ? r1_out   : {32'b0, r0_out};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntot++;
        if (obs === exp) npass++;
        else $display("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    // RISC-V division semantics plus the latency rule: special cases take
    // two cycles, otherwise 3 + ceil(bitlength(|A|) / radix bits).
    function automatic void model(input bit w64, input bit uns, input bit rm,
                                  input logic [63:0] a_in, input logic [63:0] b_in,
                                  output logic [63:0] r, output int lat);
        logic [63:0] mask, a, b, q, rr, mag;
        longint      sa, sb;
        int          bpc, nb;
        mask = w64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        a    = a_in & mask;
        b    = b_in & mask;
        bpc  = w64 ? 4 : 1;
        sa   = w64 ? longint'(a) : longint'(signed'(a[31:0]));
        sb   = w64 ? longint'(b) : longint'(signed'(b[31:0]));
        if (b == 64'd0) begin
            q = mask; rr = a; lat = 2;
        end else if (!uns && sb == -1 && a == (mask ^ (mask >> 1))) begin
            q = a; rr = 64'd0; lat = 2;
        end else begin
            if (uns) begin
                q = a / b; rr = a % b; mag = a;
            end else begin
                q = 64'(sa / sb); rr = 64'(sa % sb);
                mag = (sa < 0) ? 64'(-sa) : 64'(sa);
            end
            nb = 0;
            for (int i = 0; i < 64; i++) if (mag[i]) nb = i + 1;
            lat = 3 + (nb + bpc - 1) / bpc;
        end
        r = (rm ? rr : q) & mask;
    endfunction

    // Issue one op on instance s and follow it to completion. With b2b the
    // caller is already at the negedge of the previous op's DONE cycle.
    task automatic go(input bit s, input bit uns, input bit rm,
                      input logic [63:0] a, input logic [63:0] b, input bit tid,
                      input bit b2b, input int kill_at, input bit ktid);
        logic [63:0] exp;
        int          lat, k;
        bit          kill, seen;
        if (!b2b) begin
            @(negedge clk);
            sel = s;
        end
        model(s, uns, rm, a, b, exp, lat);
        kill      = (kill_at > 0) && (ktid == tid);
        in_valid  = 1'b1;
        in_tid    = tid;
        in_unsign = uns;
        in_rem    = rm;
        dividend  = a;
        divisor   = b;
        chk("in_ready", 64'(m_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        k = 1;
        seen = 0;
        while (k <= 80 && !seen) begin
            if (m_valid) seen = 1;
            else begin
                cancel     = (k == kill_at);
                cancel_tid = ktid;
                if (kill && k == kill_at + 1) begin
                    chk("cancel_busy", 64'(m_busy), 64'd0);
                    chk("cancel_ready", 64'(m_ready), 64'd1);
                end
                @(negedge clk);
                k++;
            end
        end
        cancel = 1'b0;
        if (kill) begin
            chk("cancel_no_valid", 64'(seen), 64'd0);
            chk("cancel_out_held", m_out, prev[s]);
        end else begin
            chk("latency", 64'(k), 64'(lat));
            chk("result", m_out, exp);
            chk("out_tid", 64'(m_tid), 64'(tid));
            prev[s] = exp;
        end
    endtask

    function automatic logic [63:0] pick(input bit w64);
        logic [63:0] v;
        v = {$urandom(), $urandom()};
        case ($urandom_range(0, 5))
            0: v = 64'($urandom_range(0, 20));
            1: v = v;
            2: v = 64'd0;
            3: v = w64 ? 64'h8000_0000_0000_0000 : 64'h8000_0000;
            4: v = v >> $urandom_range(0, 63);
            default: v = w64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
        endcase
        return v;
    endfunction

    initial begin
        prev[0] = '0;
        prev[1] = '0;
        // Reset state on both instances.
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("rst_ready", 64'(m_ready), 64'd0);
            chk("rst_busy",  64'(m_busy),  64'd0);
            chk("rst_valid", 64'(m_valid), 64'd0);
            chk("rst_out",   m_out,        64'd0);
        end
        rst = 1'b0;
        sel = 1'b0;

        // 32-bit directed cases.
        go(0, 0, 0, 64'd100, 64'd7, 0, 0, 0, 0);
        go(0, 0, 1, 64'd100, 64'd7, 1, 0, 0, 0);
        go(0, 0, 0, 64'hFFFF_FFF9, 64'd2, 0, 0, 0, 0);
        go(0, 0, 1, 64'hFFFF_FFF9, 64'd2, 1, 0, 0, 0);
        go(0, 1, 1, 64'hFFFF_FFF9, 64'd2, 0, 0, 0, 0);
        go(0, 1, 0, 64'd5, 64'd0, 1, 0, 0, 0);
        go(0, 0, 1, 64'd5, 64'd0, 0, 0, 0, 0);
        go(0, 0, 0, 64'h8000_0000, 64'hFFFF_FFFF, 1, 0, 0, 0);
        go(0, 0, 1, 64'h8000_0000, 64'hFFFF_FFFF, 0, 0, 0, 0);
        go(0, 0, 0, 64'd0, 64'd5, 1, 0, 0, 0);
        go(0, 0, 0, 64'd100, 64'd7, 1, 0, 4, 1);   // matching cancel in ITER
        go(0, 0, 0, 64'd100, 64'd7, 1, 0, 4, 0);   // other thread's cancel

        // Request flushed in its own offer cycle is dropped.
        @(negedge clk);
        in_valid = 1'b1; in_tid = 1'b0; dividend = 64'd50; divisor = 64'd3;
        cancel = 1'b1; cancel_tid = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; cancel = 1'b0;
        chk("drop_busy", 64'(m_busy), 64'd0);

        for (int i = 0; i < 40; i++)
            go(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               pick(0), pick(0), 1'($urandom_range(0, 1)), 0, 0, 0);

        // 64-bit radix-16: worst-ish case then back-to-back issue.
        go(1, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 1, 0, 0, 0);
        go(1, 1, 0, 64'd9, 64'd3, 0, 1, 0, 0);
        for (int i = 0; i < 25; i++)
            go(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               pick(1), pick(1), 1'($urandom_range(0, 1)), 0, 0, 0);
        go(1, 0, 1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 0);

        // Reset in the middle of an iteration.
        @(negedge clk);
        in_valid = 1'b1; in_tid = 1'b1; in_unsign = 1'b1; in_rem = 1'b0;
        dividend = 64'hFFFF_FFFF_FFFF_FFFF; divisor = 64'd7;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_busy", 64'(m_busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 64'(m_ready), 64'd0);
        @(negedge clk);
        chk("mid_rst_out",   m_out,        64'd0);
        chk("mid_rst_tid",   64'(m_tid),   64'd0);
        chk("mid_rst_valid", 64'(m_valid), 64'd0);
        chk("mid_rst_busy",  64'(m_busy),  64'd0);
        rst = 1'b0;
        prev[0] = '0;
        prev[1] = '0;
        go(1, 1, 0, 64'd9, 64'd3, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/eh2_exu_div_gen.md
# eh2_exu_div_gen

Parametrised iterative integer divider for the EH2 execution unit. It supersedes the fixed 32-bit, 1-bit-per-cycle divider with the following additions:

- configurable operand width and radix (quotient bits per cycle);
- leading-zero early-out;
- fixed-latency handling of RISC-V divide-by-zero and signed-overflow cases;
- per-thread cancel;
- back-to-back issue.

It sits beside the multiplier in the EXU and returns results to the writeback arbiter.

## Interface
Parameters:
- WIDTH, 32, operand/result width; legal 32 or 64.
- BPC, 1, quotient bits retired per iteration cycle; legal 1, 2, 4; WIDTH % BPC == 0.
- NUM_THREADS, 2, hardware threads; power of 2. TIDW = max(1, $clog2(NUM_THREADS)).

Ports:
- clk  in  1  clock. One clock domain.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operation request.
- in_ready  out  1  request accepted when in_valid & in_ready.
- in_tid  in  TIDW  issuing thread.
- in_unsign  in  1  1 = DIVU/REMU, 0 = DIV/REM.
- in_rem  in  1  1 = return remainder, 0 = quotient.
- dividend  in  WIDTH  operand A.
- divisor  in  WIDTH  operand B.
- cancel  in  1  flush request.
- cancel_tid  in  TIDW  thread being flushed.
- busy  out  1  state != IDLE.
- out_valid  out  1  one-cycle result strobe; no backpressure.
- out_tid  out  TIDW  thread of the result.
- out  out  WIDTH  result, held until the next completion.

## Operation
- FSM states: IDLE, SKIP, ITER, FIX, DONE.
- IDLE → SKIP on accept. Accept latches tid, unsign, rem, operand magnitudes and the signs.
  - neg_a = ~unsign & A[W-1]; neg_b likewise for B.
  - Magnitudes are unsigned WIDTH-bit values. |0x80..0| = 0x80..0.
- SKIP:
  - Detect special cases:
    - divisor == 0 → quotient all-ones, remainder = A.
    - Signed A == most-negative and B == all-ones → quotient = A, remainder = 0.
  - If special, load the result and go to DONE.
  - Otherwise compute lz = leading zeros of |A| (WIDTH when |A| = 0).
  - skip = lz − (lz mod BPC). Pre-shift |A| left by skip. N = (WIDTH − skip)/BPC.
  - Go to ITER, or to FIX if N == 0.
- ITER: each cycle runs BPC cascaded restoring steps.
  - Each step: shift the partial remainder left, bring in the next dividend bit, compare with |B|, subtract if ≥, shift in the quotient bit.
  - Decrement the count; go to FIX after the N-th cycle.
- FIX:
  - Quotient is negated if ~unsign & (neg_a ^ neg_b).
  - Remainder is negated if ~unsign & neg_a.
  - Select by rem, register into out/out_tid, go to DONE.
- DONE: out_valid = 1 unless cancelled.
  - If a new request is accepted this cycle → SKIP, otherwise → IDLE.
- in_ready = ~rst & (state == IDLE | state == DONE).
- Cancel:
  - cancel & cancel_tid == active tid, in any non-IDLE state → IDLE next cycle. out_valid is suppressed combinationally in DONE. out keeps its previous value.
  - A non-matching cancel_tid has no effect.
  - A same-cycle accept whose in_tid matches cancel_tid is dropped; the FSM stays or returns to IDLE.
- Reset (any cycle, including mid-operation):
  - Next state IDLE. out_valid = 0, out = 0, out_tid = 0, busy = 0.
  - in_ready is 0 while rst is high.

## Timing
Accept at cycle T.
- Special case: SKIP at T+1, out_valid at T+2.
- Normal case: SKIP at T+1, ITER T+2..T+1+N, FIX T+2+N, out_valid at T+3+N.
  - Worst case is N = WIDTH/BPC.
  - Dividend 0: N = 0, out_valid at T+3.
- Back-to-back: a second request accepted in the DONE cycle of the first enters SKIP the following cycle. There are no bubbles beyond the fixed latency.
- out, out_tid and the state register are flop outputs.
- out_valid = (state == DONE) & ~(cancel & cancel_tid == tid_q).

## Structure
- eh2_pkg gains:
  - eh2_div_gen_state_t, the 5-state enum;
  - eh2_div_gen_pkt_t {valid, unsign, rem, tid}.
- Sub-module eh2_div_lzc:
  - parametrised WIDTH leading-zero counter;
  - output width $clog2(WIDTH)+1;
  - returns WIDTH for an all-zero input.
- The BPC-step iteration array is a generate loop inside eh2_exu_div_gen.

## Test plan
- WIDTH=32, BPC=1, DIV 100/7: lz = 25, N = 7, out = 14 at T+10. REM of the same operands: out = 2 at T+10.
- Signed DIV −7/2 → 0xFFFFFFFD (−3). REM −7/2 → 0xFFFFFFFF (−1). REMU 0xFFFFFFF9/2 → 1.
- DIVU 5/0 → 0xFFFFFFFF at T+2. REM 5/0 → 5 at T+2.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000 at T+2. REM of the same operands → 0.
- Cancel in ITER:
  - matching tid: no out_valid, busy = 0 and in_ready = 1 the next cycle;
  - cancel_tid ≠ tid: result delivered unchanged.
- WIDTH=64, BPC=4, DIVU 0xFFFF_FFFF_FFFF_FFFF/3:
  - N = 16, out = 0x5555_5555_5555_5555 at T+19.
  - A second DIVU 9/3 accepted in that DONE cycle (T+19) → out = 3, out_valid at T+23.
  - rst asserted mid-ITER → all outputs 0 the next cycle.
